// File: rtl/pfiform_pkg.sv
// Shared constants, width helpers and sample type for the multi-lane soft-bit
// packing FIFO family.
package pfiform_pkg;

  localparam int DEF_SAMPLE_W = 6;
  localparam int DEF_LANES    = 32;
  localparam int DEF_DEPTH    = 64;

  function automatic int amt_w(input int lanes);
    return $clog2(lanes);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [DEF_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/pfiform_multi_if.sv
// Writer/reader/status bundle of pfiform_multi; the slave modport is the FIFO
// side, the master modport is the surrounding datapath (or bench).
interface pfiform_multi_if
  import pfiform_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int LANES    = DEF_LANES,
  parameter int DEPTH    = DEF_DEPTH
);
  localparam int AMT_W = amt_w(LANES);
  localparam int LVL_W = lvl_w(DEPTH);

  logic                      i_flush;
  logic                      i_join_en;
  logic                      o_join_permit;
  logic [AMT_W-1:0]          i_join_amt;
  logic [LANES*SAMPLE_W-1:0] i_join_data;
  logic                      i_pop_permit;
  logic [AMT_W-1:0]          i_pop_amt;
  logic [LANES*SAMPLE_W-1:0] o_pop_data;
  logic                      o_pop_en;
  logic [LVL_W-1:0]          o_level;
  logic                      o_empty;
  logic                      o_full;

  modport slave (
    input  i_flush, i_join_en, i_join_amt, i_join_data, i_pop_permit, i_pop_amt,
    output o_join_permit, o_pop_data, o_pop_en, o_level, o_empty, o_full
  );

  modport master (
    output i_flush, i_join_en, i_join_amt, i_join_data, i_pop_permit, i_pop_amt,
    input  o_join_permit, o_pop_data, o_pop_en, o_level, o_empty, o_full
  );

endinterface

// File: rtl/pfiform_lane_mask.sv
// Thermometer mask: bit k is set when k <= i_amt (i.e. i_amt+1 lanes valid).
module pfiform_lane_mask
  import pfiform_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  localparam int AMT_W = amt_w(LANES)
) (
  input  logic [AMT_W-1:0] i_amt,
  output logic [LANES-1:0] o_mask
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    o_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      o_mask[k] = (k <= int'(i_amt));
    end
  end

endmodule

// File: rtl/pfiform_multi.sv
// Multi-lane soft-bit packing FIFO: 1..LANES samples joined and popped per
// cycle, head at index 0. Optional PFIFORM_MULTI_PEAK_EN adds o_peak_level.
module pfiform_multi
  import pfiform_pkg::*;
#(
  parameter  int SAMPLE_W   = DEF_SAMPLE_W,
  parameter  int LANES      = DEF_LANES,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int POP_CREDIT = 0,
  localparam int LVL_W      = lvl_w(DEPTH)
) (
  input logic              i_core_clk,
  input logic              i_rx_rst,
  pfiform_multi_if.slave   bus
`ifdef PFIFORM_MULTI_PEAK_EN
  ,
  output logic [LVL_W-1:0] o_peak_level
`endif
);

  localparam int LVL_E = LVL_W + 1;

  logic [SAMPLE_W-1:0]       r_mem     [DEPTH];
  logic [SAMPLE_W-1:0]       w_mem_nxt [DEPTH];
  logic [LVL_W-1:0]          r_level;

  logic [LANES-1:0]          w_pop_mask;
  logic [LANES-1:0]          w_join_mask;
  logic [LVL_E-1:0]          w_lvl_x;
  logic [LVL_E-1:0]          w_pop_n;
  logic [LVL_E-1:0]          w_join_n;
  logic [LVL_E-1:0]          w_lvl_eff;
  logic [LVL_E-1:0]          w_popped;
  logic [LVL_E-1:0]          w_base;
  logic [LVL_E-1:0]          w_lvl_nxt;
  logic                      w_pop_en;
  logic                      w_join_permit;
  logic                      w_join_acc;
  logic [LANES*SAMPLE_W-1:0] w_pop_data;

  pfiform_lane_mask #(.LANES(LANES)) u_pop_mask (
    .i_amt  (bus.i_pop_amt),
    .o_mask (w_pop_mask)
  );

  pfiform_lane_mask #(.LANES(LANES)) u_join_mask (
    .i_amt  (bus.i_join_amt),
    .o_mask (w_join_mask)
  );

  // Level bookkeeping is one bit wider than o_level so sums never wrap.
  assign w_lvl_x       = LVL_E'(r_level);
  assign w_pop_n       = LVL_E'(bus.i_pop_amt) + LVL_E'(1);
  assign w_join_n      = LVL_E'(bus.i_join_amt) + LVL_E'(1);
  assign w_pop_en      = bus.i_pop_permit & (w_lvl_x >= w_pop_n) & ~bus.i_flush;
  assign w_lvl_eff     = ((POP_CREDIT != 0) && w_pop_en) ? (w_lvl_x - w_pop_n) : w_lvl_x;
  assign w_join_permit = ((w_lvl_eff + w_join_n) <= LVL_E'(DEPTH)) & ~bus.i_flush;
  assign w_join_acc    = bus.i_join_en & w_join_permit;
  assign w_popped      = w_pop_en ? w_pop_n : '0;
  assign w_base        = w_lvl_x - w_popped;
  assign w_lvl_nxt     = w_base + (w_join_acc ? w_join_n : '0);

  // Pop shifts the array down first; joined lanes then land right after the survivors.
  always_comb begin
    int src;
    int off;
    for (int i = 0; i < DEPTH; i++) begin
      src          = i + int'(w_popped);
      off          = i - int'(w_base);
      w_mem_nxt[i] = '0;
      if (src < DEPTH) begin
        w_mem_nxt[i] = r_mem[src];
      end
      if (w_join_acc && (off >= 0) && (off < LANES)) begin
        if (w_join_mask[off]) begin
          w_mem_nxt[i] = bus.i_join_data[off*SAMPLE_W +: SAMPLE_W];
        end
      end
      if (i >= int'(w_lvl_nxt)) begin
        w_mem_nxt[i] = '0;
      end
    end
  end

  always_comb begin
    w_pop_data = '0;
    for (int k = 0; k < LANES; k++) begin
      w_pop_data[k*SAMPLE_W +: SAMPLE_W] = w_pop_mask[k] ? r_mem[k] : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the storage is a flop shift array, not a RAM, so it is reset like any other register.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      r_level <= '0;
      r_mem   <= '{default: '0};
    end else if (bus.i_flush) begin
      r_level <= '0;
      r_mem   <= '{default: '0};
    end else begin
      r_level <= LVL_W'(w_lvl_nxt);
      r_mem   <= w_mem_nxt;
    end
  end

`ifdef PFIFORM_MULTI_PEAK_EN
  logic [LVL_W-1:0] r_peak;

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      r_peak <= '0;
    end else if (bus.i_flush) begin
      r_peak <= '0;
    end else if (w_lvl_nxt > LVL_E'(r_peak)) begin
      r_peak <= LVL_W'(w_lvl_nxt);
    end
  end

  assign o_peak_level = r_peak;
`endif

  assign bus.o_join_permit = w_join_permit;
  assign bus.o_pop_en      = w_pop_en;
  assign bus.o_pop_data    = w_pop_data;
  assign bus.o_level       = r_level;
  assign bus.o_empty       = (r_level == '0);
  assign bus.o_full        = (r_level == LVL_W'(DEPTH));

endmodule

// File: tb/tb_pfiform_multi.sv
// Bench for pfiform_multi: two instances (POP_CREDIT=0 and 1) on shared stimulus,
// directed vectors followed by a randomised run against an array model.
module tb_pfiform_multi;
  import pfiform_pkg::*;

  localparam int SW = 6;
  localparam int LN = 32;
  localparam int DP = 64;
  localparam int DW = SW * LN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          t_flush = 1'b0;
  logic          t_join_en = 1'b0;
  logic [4:0]    t_join_amt = '0;
  logic [DW-1:0] t_join_data = '0;
  logic          t_pop_permit = 1'b0;
  logic [4:0]    t_pop_amt = '0;

  int n_checks = 0;
  int n_errors = 0;

  sample_t m_mem [2][DP];
  int      m_lvl [2];
  int      m_peak[2];

  always #5 clk = ~clk;

  pfiform_multi_if #(.SAMPLE_W(SW), .LANES(LN), .DEPTH(DP)) if0 ();
  pfiform_multi_if #(.SAMPLE_W(SW), .LANES(LN), .DEPTH(DP)) if1 ();

  assign if0.i_flush      = t_flush;
  assign if0.i_join_en    = t_join_en;
  assign if0.i_join_amt   = t_join_amt;
  assign if0.i_join_data  = t_join_data;
  assign if0.i_pop_permit = t_pop_permit;
  assign if0.i_pop_amt    = t_pop_amt;
  assign if1.i_flush      = t_flush;
  assign if1.i_join_en    = t_join_en;
  assign if1.i_join_amt   = t_join_amt;
  assign if1.i_join_data  = t_join_data;
  assign if1.i_pop_permit = t_pop_permit;
  assign if1.i_pop_amt    = t_pop_amt;

`ifdef PFIFORM_MULTI_PEAK_EN
  logic [6:0] peak0, peak1;
`endif

  pfiform_multi #(.SAMPLE_W(SW), .LANES(LN), .DEPTH(DP), .POP_CREDIT(0)) dut0 (
    .i_core_clk   (clk),
    .i_rx_rst     (rst),
    .bus          (if0)
`ifdef PFIFORM_MULTI_PEAK_EN
    , .o_peak_level (peak0)
`endif
  );

  pfiform_multi #(.SAMPLE_W(SW), .LANES(LN), .DEPTH(DP), .POP_CREDIT(1)) dut1 (
    .i_core_clk   (clk),
    .i_rx_rst     (rst),
    .bus          (if1)
`ifdef PFIFORM_MULTI_PEAK_EN
    , .o_peak_level (peak1)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic sample_t sv(input int n);
    return sample_t'((n % 63) + 1);
  endfunction

  // Lanes below cnt carry sv(n0+k); the rest carry junk the DUT must ignore.
  function automatic logic [DW-1:0] make_data(input int n0, input int cnt);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < LN; k++) d[k*SW +: SW] = (k < cnt) ? sv(n0 + k) : 6'h2A;
    return d;
  endfunction

  function automatic logic [DW-1:0] exp_lanes(input int n0, input int cnt);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < cnt; k++) d[k*SW +: SW] = sv(n0 + k);
    return d;
  endfunction

  task automatic set_in(input logic fl, input logic je, input int ja, input logic [DW-1:0] jd,
                        input logic pp, input int pa);
    t_flush      = fl;
    t_join_en    = je;
    t_join_amt   = 5'(ja);
    t_join_data  = jd;
    t_pop_permit = pp;
    t_pop_amt    = 5'(pa);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_level(input string tag, input int exp0, input int exp1);
    check({tag, " d0 level"}, if0.o_level, exp0);
    check({tag, " d1 level"}, if1.o_level, exp1);
  endtask

  // One randomised cycle: compare combinational outputs, advance model, compare state.
  task automatic rand_cycle();
    logic          fl, je, pp, pe, jp;
    int            ja, pa, lvl, eff;
    logic [DW-1:0] jd, ed, gd;
    logic          gpe, gjp;
    fl = ($urandom_range(127) == 0);
    je = ($urandom_range(9) < 7);
    pp = ($urandom_range(9) < 7);
    ja = $urandom_range(31);
    pa = $urandom_range(31);
    for (int k = 0; k < LN; k++) jd[k*SW +: SW] = SW'($urandom);
    set_in(fl, je, ja, jd, pp, pa);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      lvl = m_lvl[d];
      pe  = pp && (lvl >= pa + 1) && !fl;
      eff = (d == 1 && pe) ? lvl - pa - 1 : lvl;
      jp  = (eff + ja + 1 <= DP) && !fl;
      ed  = '0;
      for (int k = 0; k <= pa; k++) if (k < lvl) ed[k*SW +: SW] = m_mem[d][k];
      gpe = d ? if1.o_pop_en : if0.o_pop_en;
      gjp = d ? if1.o_join_permit : if0.o_join_permit;
      gd  = d ? if1.o_pop_data : if0.o_pop_data;
      check($sformatf("rnd d%0d pop_en", d), gpe, pe);
      check($sformatf("rnd d%0d join_permit", d), gjp, jp);
      check($sformatf("rnd d%0d pop_data", d), gd, ed);
      if (fl) begin
        lvl = 0;
        m_peak[d] = 0;
      end else begin
        if (pe) begin
          for (int i = 0; i < DP; i++) m_mem[d][i] = (i + pa + 1 < DP) ? m_mem[d][i + pa + 1] : '0;
          lvl = lvl - pa - 1;
        end
        if (je && jp) begin
          for (int k = 0; k <= ja; k++) m_mem[d][lvl + k] = jd[k*SW +: SW];
          lvl = lvl + ja + 1;
        end
        if (lvl > m_peak[d]) m_peak[d] = lvl;
      end
      m_lvl[d] = lvl;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rnd d%0d level", d), d ? if1.o_level : if0.o_level, m_lvl[d]);
      check($sformatf("rnd d%0d level<=DEPTH", d), (d ? if1.o_level : if0.o_level) <= 7'(DP), 1'b1);
      check($sformatf("rnd d%0d full", d), d ? if1.o_full : if0.o_full, m_lvl[d] == DP);
`ifdef PFIFORM_MULTI_PEAK_EN
      check($sformatf("rnd d%0d peak", d), d ? peak1 : peak0, m_peak[d]);
`endif
    end
  endtask

  initial begin
    // Reset state
    set_in(1'b0, 1'b0, 0, '0, 1'b0, 0);
    #2;
    check("rst d0 level", if0.o_level, 0);
    check("rst d0 empty", if0.o_empty, 1'b1);
    check("rst d0 full", if0.o_full, 1'b0);
    check("rst d0 join_permit", if0.o_join_permit, 1'b1);
    check("rst d0 pop_en", if0.o_pop_en, 1'b0);
    check("rst d0 pop_data", if0.o_pop_data, 0);
    check("rst d1 join_permit", if1.o_join_permit, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Join {1,2,3,4}, then pop two
    set_in(1'b0, 1'b1, 3, make_data(0, 4), 1'b0, 0);
    @(negedge clk);
    check("j4 join_permit", if0.o_join_permit, 1'b1);
    tick();
    check_level("j4", 4, 4);
    check("j4 empty", if0.o_empty, 1'b0);
    set_in(1'b0, 1'b0, 0, '0, 1'b1, 1);
    @(negedge clk);
    check("p2 pop_en", if0.o_pop_en, 1'b1);
    check("p2 pop_data", if0.o_pop_data, 12'h081);
    tick();
    check_level("p2", 2, 2);
    set_in(1'b1, 1'b0, 0, '0, 1'b0, 0);
    tick();
    check_level("flush1", 0, 0);

    // Fill to DEPTH, then a blocked single-sample join
    set_in(1'b0, 1'b1, 31, make_data(0, 32), 1'b0, 0);
    tick();
    set_in(1'b0, 1'b1, 31, make_data(32, 32), 1'b0, 0);
    tick();
    check_level("fill", 64, 64);
    check("fill d0 full", if0.o_full, 1'b1);
    check("fill d1 full", if1.o_full, 1'b1);
    set_in(1'b0, 1'b1, 0, make_data(200, 1), 1'b0, 0);
    @(negedge clk);
    check("full d0 join_permit", if0.o_join_permit, 1'b0);
    check("full d1 join_permit", if1.o_join_permit, 1'b0);
    check("full head data", if0.o_pop_data, exp_lanes(0, 1));
    tick();
    check_level("full hold", 64, 64);
`ifdef PFIFORM_MULTI_PEAK_EN
    check("fill d0 peak", peak0, 64);
`endif

    // Drop to 60, then join 8 + pop 8 in the same cycle
    set_in(1'b0, 1'b0, 0, '0, 1'b1, 3);
    @(negedge clk);
    check("p4 pop_data", if0.o_pop_data, exp_lanes(0, 4));
    tick();
    check_level("lvl60", 60, 60);
    set_in(1'b0, 1'b1, 7, make_data(64, 8), 1'b1, 7);
    @(negedge clk);
    check("jp8 d0 join_permit", if0.o_join_permit, 1'b0);
    check("jp8 d1 join_permit", if1.o_join_permit, 1'b1);
    check("jp8 d0 pop_en", if0.o_pop_en, 1'b1);
    check("jp8 d1 pop_en", if1.o_pop_en, 1'b1);
    check("jp8 d1 pop_data", if1.o_pop_data, exp_lanes(4, 8));
    tick();
    check_level("jp8", 52, 60);

    // Level 2, over-sized pop request
    set_in(1'b1, 1'b0, 0, '0, 1'b0, 0);
    tick();
    set_in(1'b0, 1'b1, 1, make_data(100, 2), 1'b0, 0);
    tick();
    set_in(1'b0, 1'b0, 0, '0, 1'b1, 4);
    @(negedge clk);
    check("big pop d0 pop_en", if0.o_pop_en, 1'b0);
    check("big pop d1 pop_en", if1.o_pop_en, 1'b0);
    check("big pop masked data", if0.o_pop_data, exp_lanes(100, 2));
    tick();
    check_level("big pop", 2, 2);

    // Level 20, flush with a concurrent join
    set_in(1'b0, 1'b1, 17, make_data(102, 18), 1'b0, 0);
    tick();
    check_level("lvl20", 20, 20);
`ifdef PFIFORM_MULTI_PEAK_EN
    check("lvl20 d1 peak", peak1, 20);
`endif
    set_in(1'b1, 1'b1, 0, make_data(150, 1), 1'b1, 0);
    @(negedge clk);
    check("flush d0 join_permit", if0.o_join_permit, 1'b0);
    check("flush d1 pop_en", if1.o_pop_en, 1'b0);
    tick();
    check_level("flush2", 0, 0);
    check("flush2 d0 empty", if0.o_empty, 1'b1);
`ifdef PFIFORM_MULTI_PEAK_EN
    check("flush2 d0 peak", peak0, 0);
    check("flush2 d1 peak", peak1, 0);
`endif

    // Empty: no pop at any amount, storage cleared
    set_in(1'b0, 1'b0, 0, '0, 1'b1, 31);
    @(negedge clk);
    check("empty pop_en", if0.o_pop_en, 1'b0);
    check("empty pop_data", if0.o_pop_data, 0);
    tick();

    // Randomised traffic against the model
    for (int d = 0; d < 2; d++) begin
      m_lvl[d]  = 0;
      m_peak[d] = 0;
      for (int i = 0; i < DP; i++) m_mem[d][i] = '0;
    end
    for (int c = 0; c < 3000; c++) rand_cycle();

    set_in(1'b0, 1'b0, 0, '0, 1'b0, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
